// File: rtl/irq_pkg.sv
// Shared definitions for irq_controller: FSM state encoding, the fixed-priority
// encoder (lowest index wins) and a clog2 helper for elaboration checks.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } irq_state_t;

  localparam int MAX_IRQ = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Scans from the top down so the lowest set index is the last one written.
  function automatic logic [3:0] prio_enc(input logic [MAX_IRQ-1:0] req);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser plus delay flop for one asynchronous request line;
// o_rise is high for one cycle per synchronised low-to-high transition.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes the chain a shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/irq_controller.sv
// Edge-latching, masked, fixed-priority interrupt issuer with post-pulse hold-off.
// Optional sticky overrun flags are enabled by defining IRQ_OVERRUN_EN.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_IRQ  = 4,
  parameter int HOLDOFF  = 4,
  parameter int IRQ_ID_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  input  logic                clear_en,
  input  logic [IRQ_ID_W-1:0] clear_id,
  output logic                interrupt,
  output logic [IRQ_ID_W-1:0] irq_id,
  output logic [NUM_IRQ-1:0]  pending,
  output logic                busy
`ifdef IRQ_OVERRUN_EN
  ,
  input  logic                overrun_clr,
  output logic [NUM_IRQ-1:0]  overrun
`endif
);

  localparam int CNT_W = (clog2(HOLDOFF) < 1) ? 1 : clog2(HOLDOFF);

  if (IRQ_ID_W != clog2(NUM_IRQ)) begin : g_bad_id_w
    $error("irq_controller: IRQ_ID_W must equal clog2(NUM_IRQ)");
  end
  if (NUM_IRQ < 2 || NUM_IRQ > MAX_IRQ || HOLDOFF < 1) begin : g_bad_params
    $error("irq_controller: NUM_IRQ must be 2..16 and HOLDOFF >= 1");
  end

  logic [NUM_IRQ-1:0]  w_rise;
  logic [NUM_IRQ-1:0]  w_req;
  logic [NUM_IRQ-1:0]  w_clr;
  logic [NUM_IRQ-1:0]  w_auto_clr;
  logic [IRQ_ID_W-1:0] w_sel;
  logic                w_take;

  logic [NUM_IRQ-1:0]  r_pending;
  logic [IRQ_ID_W-1:0] r_irq_id;
  logic [CNT_W-1:0]    r_cnt;
  irq_state_t          r_state;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    irq_sync_edge u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (irq_in[i]),
      .o_rise  (w_rise[i])
    );
  end

  assign w_req  = r_pending & ~irq_mask;
  assign w_take = (r_state == IDLE) && (|w_req);
  assign w_sel  = IRQ_ID_W'(prio_enc(MAX_IRQ'(w_req)));

  // Out-of-range clear_id values never match a line index and fall through.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a bit unassigned and infer a latch.
  always_comb begin
    w_clr      = '0;
    w_auto_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_clr[i]      = clear_en && (clear_id == IRQ_ID_W'(i));
      w_auto_clr[i] = w_take && (w_sel == IRQ_ID_W'(i));
    end
  end

  // A new edge is OR-ed in last so it survives a same-cycle clear or issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr & ~w_auto_clr) | w_rise;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_irq_id <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_irq_id <= w_sel;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= CNT_W'(HOLDOFF - 1);
          r_state <= HOLD;
        end
        HOLD: begin
          if (r_cnt == '0) r_state <= IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef IRQ_OVERRUN_EN
  logic [NUM_IRQ-1:0] r_overrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= '0;
    end else begin
      r_overrun <= (overrun_clr ? '0 : r_overrun)
                 | (w_rise & r_pending & ~w_clr & ~w_auto_clr);
    end
  end

  assign overrun = r_overrun;
`endif

  assign interrupt = (r_state == ISSUE);
  assign busy      = (r_state != IDLE);
  assign irq_id    = r_irq_id;
  assign pending   = r_pending;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: a cycle-numbered reference model predicts
// pulses (queued) and pending/busy; a negedge monitor pops and compares.
module tb_irq_controller;

  localparam int NUM_IRQ  = 4;
  localparam int HOLDOFF  = 4;
  localparam int IRQ_ID_W = 2;

  typedef logic [NUM_IRQ-1:0] vec_t;
  typedef struct {
    int id;
    int edge_no;
  } pulse_t;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  vec_t                irq_in = '0;
  vec_t                irq_mask = '0;
  logic                clear_en = 1'b0;
  logic [IRQ_ID_W-1:0] clear_id = '0;
  logic                interrupt;
  logic [IRQ_ID_W-1:0] irq_id;
  vec_t                pending;
  logic                busy;
`ifdef IRQ_OVERRUN_EN
  logic                overrun_clr = 1'b0;
  vec_t                overrun;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  vec_t   m_pending;
  vec_t   m_ovr;
  vec_t   hist [4];
  int     cyc;
  int     idle_from;
  int     last_issue;
  int     m_id;
  pulse_t sb[$];

  irq_controller #(
    .NUM_IRQ  (NUM_IRQ),
    .HOLDOFF  (HOLDOFF),
    .IRQ_ID_W (IRQ_ID_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .irq_mask  (irq_mask),
    .clear_en  (clear_en),
    .clear_id  (clear_id),
    .interrupt (interrupt),
    .irq_id    (irq_id),
    .pending   (pending),
    .busy      (busy)
`ifdef IRQ_OVERRUN_EN
    ,
    .overrun_clr (overrun_clr),
    .overrun     (overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model. Edge numbers count rising clock edges since reset release.
  // A line rises for the pending logic at edge e when it was sampled high at
  // e-2 and low at e-3. An issue decided at edge e blocks the next decision
  // until edge e+HOLDOFF+2.
  always @(posedge clk or negedge reset) begin : model
    vec_t rise, clr, auto_c, one;
    if (!reset) begin
      m_pending  = '0;
      m_ovr      = '0;
      for (int i = 0; i < 4; i++) hist[i] = '0;
      cyc        = 0;
      idle_from  = 0;
      last_issue = -100;
      m_id       = 0;
    end else begin
      cyc++;
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = irq_in;
      rise    = hist[2] & ~hist[3];
      one     = vec_t'(1);
      clr     = clear_en ? (one << clear_id) : '0;
      auto_c  = '0;
      if (cyc >= idle_from && (m_pending & ~irq_mask) != '0) begin
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
          if (m_pending[i] && !irq_mask[i]) m_id = i;
        end
        auto_c     = one << m_id;
        last_issue = cyc;
        idle_from  = cyc + HOLDOFF + 2;
        sb.push_back('{id: m_id, edge_no: cyc});
      end
`ifdef IRQ_OVERRUN_EN
      m_ovr = (overrun_clr ? '0 : m_ovr) | (rise & m_pending & ~auto_c & ~clr);
`endif
      m_pending = (m_pending & ~clr & ~auto_c) | rise;
    end
  end

  always @(negedge clk) begin : monitor
    pulse_t p;
    if (chk_en) begin
      if (interrupt === 1'b1) begin
        check("pulse_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          p = sb.pop_front();
          check("pulse_irq_id", int'(irq_id), p.id);
          check("pulse_edge", cyc, p.edge_no);
        end
      end
      check("interrupt", int'(interrupt), int'(cyc == last_issue));
      check("busy", int'(busy), int'(cyc >= last_issue && cyc <= last_issue + HOLDOFF));
      check("pending", int'(pending), int'(m_pending));
      check("irq_id_hold", int'(irq_id), m_id);
`ifdef IRQ_OVERRUN_EN
      check("overrun", int'(overrun), int'(m_ovr));
`endif
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    step(3);
    chk_en = 1'b1;
    reset  = 1'b1;
    step(20);

    // Single line, unmasked.
    irq_in[2] = 1'b1;
    step(3);
    irq_in[2] = 1'b0;
    step(12);

    // Simultaneous edges: lowest index first, second pulse after the hold-off.
    irq_in[1] = 1'b1;
    irq_in[3] = 1'b1;
    step(20);
    irq_in = '0;
    step(4);

    // Masked line stays pending until unmasked.
    irq_mask[0] = 1'b1;
    irq_in[0]   = 1'b1;
    step(3);
    irq_in[0] = 1'b0;
    step(10);
    check("masked_pending0", int'(pending[0]), 1);
    irq_mask[0] = 1'b0;
    step(10);

    // Clear colliding with the set edge: the set wins.
    irq_mask[2] = 1'b1;
    step(1);
    irq_in[2] = 1'b1;
    step(2);
    clear_en = 1'b1;
    clear_id = 2'd2;
    step(1);
    clear_en = 1'b0;
    step(2);
    check("set_beats_clear", int'(pending[2]), 1);
    irq_in[2] = 1'b0;
    clear_en  = 1'b1;
    step(1);
    clear_en = 1'b0;
    step(2);
    check("clear_alone", int'(pending[2]), 0);
    irq_mask[2] = 1'b0;
    step(10);

    // Reset in HOLD with a second request pending.
    irq_in[0] = 1'b1;
    irq_in[1] = 1'b1;
    step(6);
    check("hold_busy", int'(busy), 1);
    check("hold_pending1", int'(pending[1]), 1);
    #2 reset = 1'b0;
    #1;
    check("rst_interrupt", int'(interrupt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pending", int'(pending), 0);
    irq_in = '0;
    step(3);
    #2 reset = 1'b1;
    step(15);

`ifdef IRQ_OVERRUN_EN
    // Second edge on a masked, already-pending line sets the sticky flag.
    irq_mask[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      irq_in[0] = 1'b1;
      step(3);
      irq_in[0] = 1'b0;
      step(3);
    end
    step(2);
    check("overrun_set", int'(overrun[0]), 1);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    step(1);
    check("overrun_clr", int'(overrun[0]), 0);
    irq_mask[0] = 1'b0;
    step(10);
`endif

    // Randomised traffic: line toggles, mask flips and clears.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if ($urandom_range(0, 5) == 0) irq_in[i] = ~irq_in[i];
        if ($urandom_range(0, 40) == 0) irq_mask[i] = ~irq_mask[i];
      end
      clear_en = ($urandom_range(0, 9) == 0);
      clear_id = IRQ_ID_W'($urandom_range(0, NUM_IRQ - 1));
`ifdef IRQ_OVERRUN_EN
      overrun_clr = ($urandom_range(0, 30) == 0);
`endif
      step(1);
    end

    irq_in   = '0;
    irq_mask = '0;
    clear_en = 1'b0;
`ifdef IRQ_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    step(60);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
